// File: rtl/feed_ctrl_pkg.sv
// Shared definitions for the systolic array feed controller: state encoding and
// pipeline timing constants used by the FSM and the valid skew chain.
package feed_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StRead  = ST_READ,
        StDrain = ST_DRAIN,
        StDone  = ST_DONE
    } feed_state_e;

    // Buffer returns data one cycle after the read strobe.
    localparam int unsigned READ_LATENCY = 1;

    // Cycles between the last read strobe and the last lane qualifying that row.
    function automatic int unsigned drain_cycles(input int unsigned array);
        return array + READ_LATENCY;
    endfunction

endpackage

// File: rtl/valid_skew_chain.sv
// Shift chain producing per-lane valid bits: bit n is rv delayed n+1 cycles,
// matching the data skew network alignment.
module valid_skew_chain #(
    parameter int unsigned ARRAY = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rv,
    output logic [ARRAY-1:0] lane_valid
);

    logic [ARRAY-1:0] lane_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
        end else begin
            lane_q[0] <= rv;
            for (int n = 1; n < int'(ARRAY); n++) begin
                lane_q[n] <= lane_q[n-1];
            end
        end
    end

    assign lane_valid = lane_q;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Streams a descriptor-defined block of buffer rows into the systolic array skew
// network, generating skewed per-lane valids and a completion pulse after drain.
module systolic_feed_ctrl
    import feed_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ARRAY          = 16,
    parameter int unsigned MEM_DATA_WIDTH = DATA_WIDTH * ARRAY,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned LEN_WIDTH      = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ADDR_WIDTH-1:0]     cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]     cfg_stride,
    input  logic [LEN_WIDTH-1:0]      cfg_num_rows,
    input  logic                      abort,
    output logic                      buf_read_req,
    output logic [ADDR_WIDTH-1:0]     buf_read_addr,
    input  logic [MEM_DATA_WIDTH-1:0] buf_read_data,
    output logic [MEM_DATA_WIDTH-1:0] skew_data_in,
    output logic [ARRAY-1:0]          lane_valid,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned DRAIN_CYCLES = drain_cycles(ARRAY);
    localparam int unsigned DCW          = $clog2(DRAIN_CYCLES + 1);

    // Normal exit enters DRAIN straight after the last strobe. An abort spends
    // its own READ cycle without a strobe, so one drain cycle is already used.
    localparam logic [DCW-1:0] DRAIN_LOAD       = DCW'(DRAIN_CYCLES - 1);
    localparam logic [DCW-1:0] DRAIN_LOAD_ABORT = DCW'(DRAIN_CYCLES - 2);

    feed_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [LEN_WIDTH-1:0]  rows_left_q, rows_left_d;
    logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
    logic                  rv_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        stride_d     = stride_q;
        rows_left_d  = rows_left_q;
        drain_cnt_d  = drain_cnt_q;
        cfg_ready    = 1'b0;
        buf_read_req = 1'b0;
        done         = 1'b0;
        busy         = 1'b1;

        unique case (state_q)
            StIdle: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) begin
                    addr_d      = cfg_base_addr;
                    stride_d    = cfg_stride;
                    rows_left_d = cfg_num_rows;
                    state_d     = (cfg_num_rows == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (abort) begin
                    state_d     = StDrain;
                    drain_cnt_d = DRAIN_LOAD_ABORT;
                end else begin
                    buf_read_req = 1'b1;
                    addr_d       = addr_q + stride_q;
                    rows_left_d  = rows_left_q - 1'b1;
                    if (rows_left_q == LEN_WIDTH'(1)) begin
                        state_d     = StDrain;
                        drain_cnt_d = DRAIN_LOAD;
                    end
                end
            end
            StDrain: begin
                if (drain_cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            stride_q    <= '0;
            rows_left_q <= '0;
            drain_cnt_q <= '0;
            rv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            rows_left_q <= rows_left_d;
            drain_cnt_q <= drain_cnt_d;
            rv_q        <= buf_read_req;
        end
    end

    assign buf_read_addr = addr_q;
    assign skew_data_in  = buf_read_data;

    valid_skew_chain #(
        .ARRAY(ARRAY)
    ) u_valid_skew_chain (
        .clk       (clk),
        .reset     (reset),
        .rv        (rv_q),
        .lane_valid(lane_valid)
    );

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl with ARRAY=4: table of transfers plus
// hand sequences for reset mid-transfer and back-to-back descriptors.
module tb_systolic_feed_ctrl;

    localparam int A  = 4;
    localparam int DW = 8;
    localparam int MW = DW * A;
    localparam int AW = 10;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_base_addr;
    logic [AW-1:0] cfg_stride;
    logic [LW-1:0] cfg_num_rows;
    logic          abort;
    logic          buf_read_req;
    logic [AW-1:0] buf_read_addr;
    logic [MW-1:0] buf_read_data;
    logic [MW-1:0] skew_data_in;
    logic [A-1:0]  lane_valid;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    systolic_feed_ctrl #(
        .DATA_WIDTH    (DW),
        .ARRAY         (A),
        .MEM_DATA_WIDTH(MW),
        .ADDR_WIDTH    (AW),
        .LEN_WIDTH     (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_base_addr(cfg_base_addr),
        .cfg_stride   (cfg_stride),
        .cfg_num_rows (cfg_num_rows),
        .abort        (abort),
        .buf_read_req (buf_read_req),
        .buf_read_addr(buf_read_addr),
        .buf_read_data(buf_read_data),
        .skew_data_in (skew_data_in),
        .lane_valid   (lane_valid),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [AW-1:0]      base;
        logic [AW-1:0]      stride;
        logic [LW-1:0]      rows;
        int                 abort_at;     // READ cycle index to abort on, 0 = never
        int                 exp_reqs;
        logic [4:0][AW-1:0] exp_addr;     // first up to five addresses
        int                 exp_done_k;   // cycles after acceptance edge
        int                 exp_l0_first; // 0 = lane never valid
        int                 exp_l3_first;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [4:0][AW-1:0] mk_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                                   input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                                                   input logic [AW-1:0] a4);
        logic [4:0][AW-1:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int                 reqs = 0;
        int                 done_k = 0;
        int                 busy_bad = 0;
        int                 lane_cnt[A];
        int                 lane_first[A];
        logic [4:0][AW-1:0] got_addr = '0;
        int                 k = 1;
        int                 n_chk;
        for (int n = 0; n < A; n++) begin
            lane_cnt[n] = 0;
            lane_first[n] = 0;
        end
        @(negedge clk);
        cfg_valid     = 1'b1;
        cfg_base_addr = v.base;
        cfg_stride    = v.stride;
        cfg_num_rows  = v.rows;
        check($sformatf("v%0d cfg_ready idle", idx), cfg_ready, 1);
        @(posedge clk);
        #1;
        cfg_valid     = 1'b0;
        cfg_base_addr = 10'h2AA;
        cfg_stride    = 10'h155;
        cfg_num_rows  = 10'h3FF;
        while (done_k == 0 && k <= 2000) begin
            abort = (v.abort_at != 0 && k == v.abort_at);
            #1;
            if (!busy) busy_bad++;
            if (buf_read_req) begin
                if (reqs < 5) got_addr[reqs] = buf_read_addr;
                reqs++;
            end
            for (int n = 0; n < A; n++) begin
                if (lane_valid[n]) begin
                    lane_cnt[n]++;
                    if (lane_first[n] == 0) lane_first[n] = k;
                end
            end
            if (done) done_k = k;
            @(posedge clk);
            #1;
            abort = 1'b0;
            k++;
        end
        if (done_k == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL v%0d done timeout: got none expected %0d", idx, v.exp_done_k);
        end
        #1;
        check($sformatf("v%0d reqs", idx), reqs, v.exp_reqs);
        n_chk = (v.exp_reqs < 5) ? v.exp_reqs : 5;
        for (int i = 0; i < n_chk; i++)
            check($sformatf("v%0d addr%0d", idx, i), got_addr[i], v.exp_addr[i]);
        check($sformatf("v%0d done_k", idx), done_k, v.exp_done_k);
        check($sformatf("v%0d lane0_first", idx), lane_first[0], v.exp_l0_first);
        check($sformatf("v%0d lane3_first", idx), lane_first[3], v.exp_l3_first);
        for (int n = 0; n < A; n++)
            check($sformatf("v%0d lane%0d_cnt", idx, n), lane_cnt[n], v.exp_reqs);
        check($sformatf("v%0d busy_gaps", idx), busy_bad, 0);
        check($sformatf("v%0d ready_after", idx), cfg_ready, 1);
        check($sformatf("v%0d busy_after", idx), busy, 0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        check(name, done, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        vecs[0] = '{10'h010, 10'd1, 10'd3, 0, 3,
                    mk_addr(10'h010, 10'h011, 10'h012, 10'h0, 10'h0), 9, 3, 6};
        vecs[1] = '{10'h3FE, 10'd2, 10'd3, 0, 3,
                    mk_addr(10'h3FE, 10'h000, 10'h002, 10'h0, 10'h0), 9, 3, 6};
        vecs[2] = '{10'h055, 10'd3, 10'd0, 0, 0,
                    mk_addr(10'h0, 10'h0, 10'h0, 10'h0, 10'h0), 1, 0, 0};
        vecs[3] = '{10'h100, 10'd4, 10'd8, 3, 2,
                    mk_addr(10'h100, 10'h104, 10'h0, 10'h0, 10'h0), 8, 3, 6};
        vecs[4] = '{10'h005, 10'h100, 10'd1, 0, 1,
                    mk_addr(10'h005, 10'h0, 10'h0, 10'h0, 10'h0), 7, 3, 6};
        vecs[5] = '{10'h3F0, 10'd7, 10'd5, 0, 5,
                    mk_addr(10'h3F0, 10'h3F7, 10'h3FE, 10'h005, 10'h00C), 11, 3, 6};
        vecs[6] = '{10'h000, 10'd1, 10'd1023, 0, 1023,
                    mk_addr(10'h000, 10'h001, 10'h002, 10'h003, 10'h004), 1029, 3, 6};

        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_base_addr = '0;
        cfg_stride = '0;
        cfg_num_rows = '0;
        abort = 1'b0;
        buf_read_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst cfg_ready", cfg_ready, 1);
        check("rst req", buf_read_req, 0);
        check("rst addr", buf_read_addr, 0);
        check("rst lane_valid", lane_valid, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset after four reads, then a fresh descriptor right away.
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_base_addr = 10'h040;
        cfg_stride = 10'd1;
        cfg_num_rows = 10'd8;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid req4", buf_read_req, 1);
        check("mid addr4", buf_read_addr, 10'h043);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cfg_valid = 1'b1;
        cfg_base_addr = 10'h020;
        cfg_num_rows = 10'd1;
        buf_read_data = 32'hA5C3_1E07;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid rst cfg_ready", cfg_ready, 1);
        check("mid rst req", buf_read_req, 0);
        check("mid rst addr", buf_read_addr, 0);
        check("mid rst lane_valid", lane_valid, 0);
        check("mid rst busy", busy, 0);
        check("mid rst done", done, 0);
        check("skew passthrough", skew_data_in, 32'hA5C3_1E07);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        #1;
        check("post rst busy", busy, 1);
        check("post rst req", buf_read_req, 1);
        check("post rst addr", buf_read_addr, 10'h020);
        check("post rst lanes k7", lane_valid, 0);
        @(posedge clk);
        #2;
        check("post rst lanes k8", lane_valid, 0);
        @(posedge clk);
        #2;
        check("post rst lanes k9", lane_valid, 4'b0001);
        wait_done("post rst done", 20);

        // Back-to-back: cfg_valid held across the first transfer.
        begin
            int req_k[4];
            logic [AW-1:0] req_a[4];
            int nreq = 0;
            int ndone = 0;
            int first_done = 0;
            int second_done = 0;
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_base_addr = 10'h100;
            cfg_stride = 10'd1;
            cfg_num_rows = 10'd2;
            @(posedge clk);
            #1;
            cfg_base_addr = 10'h200;
            cfg_stride = 10'd3;
            cfg_num_rows = 10'd1;
            for (int k = 1; k <= 20; k++) begin
                if (first_done != 0 && k == first_done + 2) cfg_valid = 1'b0;
                #1;
                if (buf_read_req && nreq < 4) begin
                    req_k[nreq] = k;
                    req_a[nreq] = buf_read_addr;
                    nreq++;
                end
                if (done) begin
                    ndone++;
                    if (first_done == 0) first_done = k;
                    else second_done = k;
                end
                @(posedge clk);
                #1;
            end
            cfg_valid = 1'b0;
            check("b2b reqs", nreq, 3);
            check("b2b done count", ndone, 2);
            check("b2b first done", first_done, 8);
            if (nreq == 3) begin
                check("b2b gap", req_k[2] - req_k[1], A + 4);
                check("b2b addr2", req_a[2], 10'h200);
            end
            check("b2b second done", second_done, 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
Sequencer that streams a block of rows from an on-chip buffer into the input skew network of the systolic array. The skew network delays lane n by n+1 cycles.
- Accepts a transfer descriptor (base, row count, stride).
- Issues one buffer read per cycle and forwards read data to the skew network.
- Generates per-lane valid bits skewed to match the data.
- Signals completion once the last lane has drained.

Parameters:
DATA_WIDTH, 8, bits per array lane
ARRAY, 16, number of lanes / skew depth
MEM_DATA_WIDTH, DATA_WIDTH*ARRAY, buffer row width
ADDR_WIDTH, 10, buffer address width
LEN_WIDTH, 10, row-count width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cfg_valid  in  1  descriptor valid
cfg_ready  out  1  high only in IDLE
cfg_base_addr  in  ADDR_WIDTH  first row address
cfg_stride  in  ADDR_WIDTH  address increment per row
cfg_num_rows  in  LEN_WIDTH  rows to stream
abort  in  1  stop issuing reads, drain, finish
buf_read_req  out  1  buffer read strobe
buf_read_addr  out  ADDR_WIDTH  buffer read address
buf_read_data  in  MEM_DATA_WIDTH  read data, valid 1 cycle after req
skew_data_in  out  MEM_DATA_WIDTH  to skew network input
lane_valid  out  ARRAY  bit n qualifies lane n at skew network output
busy  out  1  not IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, cfg_ready=1, buf_read_req=0, buf_read_addr=0, lane_valid=0, busy=0, done=0. All counters and the valid chain are cleared.
- Reset mid-transfer: full return to IDLE next cycle. Any in-flight rows are dropped; their lane_valid bits are forced to 0.
- Handshake: descriptor accepted on cfg_valid&cfg_ready. Fields are latched at acceptance; later cfg changes are ignored.
- States: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Accept with num_rows>0 -> READ.
  - Accept with num_rows==0 -> DONE directly; no reads issued.
- READ:
  - buf_read_req=1 every cycle.
  - Address for row i = base + i*stride, computed by running addition, modulo 2^ADDR_WIDTH (wrap permitted, no error).
  - After num_rows requests -> DRAIN.
  - abort in READ: no request that cycle or after -> DRAIN. Rows already requested still flow out.
  - abort in other states: ignored.
- DRAIN: waits exactly ARRAY+1 cycles after the last request, then -> DONE.
- DONE: done=1 for one cycle -> IDLE, cfg_ready=1 on the following cycle.
- Data path: skew_data_in = buf_read_data, combinational passthrough with no added register.
- Row valid: rv = buf_read_req delayed 1 cycle.
- Skewed valid: lane_valid[n] = rv delayed n+1 cycles, i.e. buf_read_req delayed n+2 cycles. This matches the skew network data alignment.
- Latency: row issued at cycle t appears on lane n at cycle t+n+2. Last lane for last row (issued t_last) appears at t_last+ARRAY+1; done is asserted at t_last+ARRAY+2.
- busy=1 from the acceptance cycle+1 through the done cycle inclusive.
- Back-to-back: a new descriptor is accepted no earlier than the cycle after done. No overlap between transfers.
- num_rows saturating: count is full LEN_WIDTH. num_rows = 2^LEN_WIDTH-1 must work.

Decomposition:
- Shared package (feed_ctrl_pkg):
  - state encoding, 2-bit localparams ST_IDLE, ST_READ, ST_DRAIN, ST_DONE
  - READ_LATENCY=1
  - DRAIN_CYCLES = ARRAY+1
- One sub-module, valid_skew_chain (ARRAY), with resettable flops:
  - input rv
  - output lane_valid, bit n = rv delayed n+1 cycles
- Top holds the FSM, address generator and row/drain counters.

Test Plan:
- Basic transfer: ARRAY=4, base=0x010, stride=1, rows=3 → reads 0x010,0x011,0x012 on consecutive cycles. lane_valid[0] high for 3 cycles starting 2 cycles after the first req; lane_valid[3] starts 5 cycles after. done exactly 6 cycles after the last req.
- Wrap-around: base=0x3FE, stride=2, rows=3 (ADDR_WIDTH=10) → addresses 0x3FE, 0x000, 0x002. No error; done normal.
- Zero rows: cfg_num_rows=0 → no buf_read_req, done one cycle after acceptance, cfg_ready back high the next cycle.
- Abort: rows=8, abort asserted on the 3rd READ cycle → exactly 2 reads issued. Each lane_valid bit shows 2 valid cycles; done ARRAY+2 cycles after the 2nd req.
- Reset mid-transfer: rows=8, reset after 4 reads → next cycle all outputs at reset values, lane_valid=0 thereafter. A new descriptor is accepted in the following cycle.
- Back-to-back: cfg_valid held high with two descriptors → second accepted the cycle after the first done. Gap between the last req of transfer 1 and the first req of transfer 2 is ARRAY+4 cycles.
